lcd_timing_gen: RTL
===================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter DOTS_PER_LINE, default 456, meaning dot clocks per scanline.
REQ-002 SHALL have parameter OAM_DOTS, default 80, meaning mode-2 length in dots.
REQ-003 SHALL have parameter XFER_DOTS, default 172, meaning mode-3 length in dots.
REQ-004 SHALL have parameters VISIBLE_LINES, default 144, and TOTAL_LINES, default 154.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  dot clock, all state on rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports lcd_en  in  1  LCDC bit 7; addr  in  16  bus address; wdata  in  8  write data; wr  in  1  write strobe; rd  in  1  read strobe.
REQ-007 SHALL have ports rdata  out  8  read data; rd_hit  out  1  rdata valid and owned.
REQ-008 SHALL have ports drawline  out  1  one-cycle render request; line_idx  out  8  line to render; frame_done  out  1  one-cycle pulse at line 144 start.
REQ-009 SHALL have ports ly  out  8  current line; mode  out  2  STAT mode; vblank_irq  out  1  one-cycle pulse; stat_irq  out  1  one-cycle pulse.

Function
REQ-010 SHALL keep dot counter 0..DOTS_PER_LINE-1 and line counter 0..TOTAL_LINES-1; dot wraps to 0 and line increments; line wraps to 0 after TOTAL_LINES-1.
REQ-011 SHALL set mode, for line < VISIBLE_LINES: 2 for dot < OAM_DOTS, 3 for dot < OAM_DOTS+XFER_DOTS, else 0; mode 1 for all other lines.
REQ-012 SHALL pulse drawline for exactly the first cycle of mode 3, with line_idx = ly held stable until the next drawline.
REQ-013 SHALL pulse vblank_irq and frame_done on the cycle entering line VISIBLE_LINES dot 0.
REQ-014 SHALL compute coincidence = (ly == lyc) combinationally from registered values.
REQ-015 SHALL form stat_line = (STAT[6]&coincidence) | (STAT[5]&mode==2) | (STAT[4]&mode==1) | (STAT[3]&mode==0); stat_irq pulses only on a 0->1 edge of stat_line (no retrigger while high).
REQ-016 SHALL decode registers: 0xFF41 STAT (bits 6:3 R/W, bit 2 coincidence RO, bits 1:0 mode RO, bit 7 reads 1); 0xFF44 LY (RO; any write zeroes dot and line); 0xFF45 LYC (R/W).
REQ-017 SHALL register reads: rdata/rd_hit valid one cycle after rd with a decoded address; rd_hit=0 and rdata=0 otherwise.
REQ-018 SHALL, while lcd_en=0: hold dot=0, ly=0, mode=0, and suppress drawline, frame_done and vblank_irq; register reads/writes still work; stat_irq edge logic still runs.
REQ-019 SHALL, on lcd_en 0->1, start at line 0 dot 0 mode 2 on the next cycle.
REQ-020 SHALL, on simultaneous write to LY and a line wrap, give the write priority (result line 0 dot 0).
REQ-021 SHALL apply a write to LYC or STAT on the next cycle; the coincidence edge fires stat_irq in that cycle if enabled.

Reset
REQ-022 SHALL asynchronously clear, on reset_n=0: dot, ly, lyc, STAT enables, line_idx, rdata, rd_hit, all pulses, and the stat_line history to 0; mode=0.
REQ-023 SHALL resume timing with the first clk after reset_n deasserts (if lcd_en=1) at line 0 dot 0; a mid-frame reset abandons the frame without a frame_done.

Structure
REQ-024 SHALL place the LCD_STAT_ADDR, LY_ADDR and LYC_ADDR constants, the mode enum (HBLANK=0, VBLANK=1, OAM=2, XFER=3) and the STAT bit-field typedef in the shared video_types package.
REQ-025 SHALL be a single module with no sub-modules; the dot and line counters live in one always_ff block.

Verification
REQ-026 SHALL run the bench with DOTS_PER_LINE=20, OAM_DOTS=4, XFER_DOTS=6, VISIBLE_LINES=3, TOTAL_LINES=5.
REQ-027 SHALL cover reset then lcd_en=1 -> mode sequence 2,3,0 per line; drawline once at dot 4 with line_idx 0,1,2; mode 1 on lines 3-4; vblank_irq once per 100 cycles.
REQ-028 SHALL cover LYC=2 with STAT[6]=1 -> single stat_irq at line 2 dot 0; STAT read shows bit 2 set, then cleared on line 3.
REQ-029 SHALL cover STAT[3]=1 and STAT[5]=1 -> stat_irq at dot 4 of no line (mode 0->2 keeps stat_line high); first stat_irq only at dot 10 of line 0.
REQ-030 SHALL cover a write to LY at line 1 dot 7 -> next cycle ly=0, mode=2; drawline re-fires 4 cycles later with line_idx 0.
REQ-031 SHALL cover lcd_en dropped mid-line 2 -> ly=0, mode=0, no drawline/vblank_irq; re-enable -> line 0 dot 0 next cycle.
REQ-032 SHALL cover reset_n pulsed mid-frame -> all outputs 0 immediately; read of 0xFF45 returns 0x00 with rd_hit=1.

Source files
------------

// File: rtl/video_types.sv
// video_types: shared LCD register addresses, STAT mode encoding and STAT register layout.
package video_types;
  localparam logic [15:0] LCD_STAT_ADDR = 16'hFF41;
  localparam logic [15:0] LY_ADDR = 16'hFF44;
  localparam logic [15:0] LYC_ADDR = 16'hFF45;
  typedef enum logic [1:0] {HBLANK = 2'd0, VBLANK = 2'd1, OAM = 2'd2, XFER = 2'd3} lcd_mode_e;
  typedef struct packed {
    logic one;
    logic lyc_ie;
    logic oam_ie;
    logic vblank_ie;
    logic hblank_ie;
    logic lyc_eq;
    lcd_mode_e mode;
  } stat_reg_t;
endpackage

// File: rtl/lcd_timing_gen_if.sv
// lcd_bus_if: CPU register bus into the LCD timing block.
interface lcd_bus_if;
  logic [15:0] addr;
  logic [7:0] wdata;
  logic wr;
  logic rd;
  logic [7:0] rdata;
  logic rd_hit;
  modport master(output addr, wdata, wr, rd, input rdata, rd_hit);
  modport slave(input addr, wdata, wr, rd, output rdata, rd_hit);
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: dot/line timing, STAT/LY/LYC registers, render request and interrupt pulses.
module lcd_timing_gen
  import video_types::*;
#(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS = 80,
  parameter int XFER_DOTS = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES = 154
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lcd_en,
  lcd_bus_if.slave bus,
  output logic drawline,
  output logic [7:0] line_idx,
  output logic frame_done,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic vblank_irq,
  output logic stat_irq
);
  localparam int DW = $clog2(DOTS_PER_LINE);
  localparam logic [DW-1:0] DOT_LAST = DW'(DOTS_PER_LINE - 1);
  localparam logic [DW-1:0] OAM_END = DW'(OAM_DOTS);
  localparam logic [DW-1:0] XFER_END = DW'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] VIS = 8'(VISIBLE_LINES);
  localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);
  logic [DW-1:0] dot_q, dot_d;
  logic [7:0] line_q, line_d, lyc_q, lyc_d, line_idx_q, line_idx_d, rdata_q, rdata_d;
  logic [3:0] ie_q, ie_d;
  logic on_q, on_d, rd_hit_q, rd_hit_d, draw_q, draw_d, vbl_q, vbl_d, stat_prev_q, stat_prev_d;
  logic ly_wr, dot_wrap, coinc, stat_line, hold;
  lcd_mode_e cur_mode;
  stat_reg_t stat_rd;
  always_comb begin
    ly_wr = bus.wr && bus.addr == LY_ADDR;
    cur_mode = !on_q ? HBLANK : line_q >= VIS ? VBLANK : dot_q < OAM_END ? OAM :
               dot_q < XFER_END ? XFER : HBLANK;
    coinc = line_q == lyc_q;
    stat_line = |(ie_q & {coinc, cur_mode == OAM, cur_mode == VBLANK, cur_mode == HBLANK});
    stat_rd = '{one: 1'b1, lyc_ie: ie_q[3], oam_ie: ie_q[2], vblank_ie: ie_q[1],
                hblank_ie: ie_q[0], lyc_eq: coinc, mode: cur_mode};
    // an LY write outranks the natural line wrap
    hold = !lcd_en || !on_q || ly_wr;
    dot_wrap = dot_q == DOT_LAST;
    dot_d = (hold || dot_wrap) ? '0 : dot_q + 1'b1;
    line_d = hold ? '0 : !dot_wrap ? line_q : line_q == LINE_LAST ? '0 : line_q + 8'd1;
    on_d = lcd_en;
    draw_d = lcd_en && line_d < VIS && dot_d == OAM_END;
    line_idx_d = draw_d ? line_d : line_idx_q;
    vbl_d = lcd_en && line_d == VIS && dot_d == '0;
    stat_prev_d = stat_line;
    lyc_d = (bus.wr && bus.addr == LYC_ADDR) ? bus.wdata : lyc_q;
    ie_d = (bus.wr && bus.addr == LCD_STAT_ADDR) ? bus.wdata[6:3] : ie_q;
    rd_hit_d = bus.rd && (bus.addr == LCD_STAT_ADDR || bus.addr == LY_ADDR || bus.addr == LYC_ADDR);
    rdata_d = !bus.rd ? '0 : bus.addr == LCD_STAT_ADDR ? stat_rd : bus.addr == LY_ADDR ? line_q :
              bus.addr == LYC_ADDR ? lyc_q : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dot_q <= '0;
      line_q <= '0;
      on_q <= 1'b0;
      lyc_q <= '0;
      ie_q <= '0;
      line_idx_q <= '0;
      rdata_q <= '0;
      rd_hit_q <= 1'b0;
      draw_q <= 1'b0;
      vbl_q <= 1'b0;
      stat_prev_q <= 1'b0;
    end else begin
      dot_q <= dot_d;
      line_q <= line_d;
      on_q <= on_d;
      lyc_q <= lyc_d;
      ie_q <= ie_d;
      line_idx_q <= line_idx_d;
      rdata_q <= rdata_d;
      rd_hit_q <= rd_hit_d;
      draw_q <= draw_d;
      vbl_q <= vbl_d;
      stat_prev_q <= stat_prev_d;
    end
  assign ly = line_q;
  assign mode = cur_mode;
  assign drawline = draw_q;
  assign line_idx = line_idx_q;
  assign frame_done = vbl_q;
  assign vblank_irq = vbl_q;
  assign stat_irq = stat_line && !stat_prev_q;
  assign bus.rdata = rdata_q;
  assign bus.rd_hit = rd_hit_q;
endmodule
